// File: rtl/router_pkg.sv
// Shared definitions for the router synchroniser: default sizing constants
// and the state encoding of the per-channel stale-data timer.
package router_pkg;

   localparam int ROUTER_NUM_CH  = 3;
   localparam int ROUTER_TIMEOUT = 30;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      FLUSH = 2'd2
   } timer_state_t;

endpackage

// File: rtl/router_sync_n_if.sv
// Bus between the router FSM, the channel FIFOs and the synchroniser.
// The master side is the environment (FSM, FIFOs, receivers); the slave side
// is router_sync_n, which decodes the destination and supervises the FIFOs.
interface router_sync_n_if
   import router_pkg::*;
#(
   parameter int NUM_CH = ROUTER_NUM_CH,
   parameter int ADDR_W = $clog2(NUM_CH)
);

   logic              detect_add;
   logic              write_enb_reg;
   logic [ADDR_W-1:0] datain;
   logic [NUM_CH-1:0] read_enb;
   logic [NUM_CH-1:0] empty;
   logic [NUM_CH-1:0] full;
   logic [NUM_CH-1:0] write_enb;
   logic              fifo_full;
   logic [NUM_CH-1:0] vld_out;
   logic [NUM_CH-1:0] soft_reset;
   logic              addr_err;

   modport master (
      output detect_add, write_enb_reg, datain, read_enb, empty, full,
      input  write_enb, fifo_full, vld_out, soft_reset, addr_err
   );

   modport slave (
      input  detect_add, write_enb_reg, datain, read_enb, empty, full,
      output write_enb, fifo_full, vld_out, soft_reset, addr_err
   );

endinterface

// File: rtl/router_timeout_timer.sv
// Per-channel stale-data watchdog. While a channel holds valid data that its
// receiver is not reading, count cycles; after TIMEOUT such consecutive
// cycles emit a one-cycle soft_reset pulse to flush that channel's FIFO.
module router_timeout_timer
   import router_pkg::*;
#(
   parameter int TIMEOUT = ROUTER_TIMEOUT
) (
   input  logic clk,
   input  logic reset,
   input  logic cond,
   output logic soft_reset
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   timer_state_t     r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_softReset;

   // Timer FSM: the pulse register is set on entry to FLUSH and cleared on exit,
   // so soft_reset is high exactly while the state is FLUSH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_softReset <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_softReset <= 1'b0;
               if (cond) begin
                  r_state <= COUNT;
                  r_cnt   <= CNT_W'(1);
               end else begin
                  r_cnt   <= '0;
               end
            end
            COUNT: begin
               if (!cond) begin
                  r_state     <= IDLE;
                  r_cnt       <= '0;
                  r_softReset <= 1'b0;
               end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                  r_state     <= FLUSH;
                  r_cnt       <= '0;
                  r_softReset <= 1'b1;
               end else begin
                  r_cnt       <= r_cnt + CNT_W'(1);
                  r_softReset <= 1'b0;
               end
            end
            FLUSH: begin
               r_state     <= IDLE;
               r_cnt       <= '0;
               r_softReset <= 1'b0;
            end
            default: begin
               r_state     <= IDLE;
               r_cnt       <= '0;
               r_softReset <= 1'b0;
            end
         endcase
      end
   end

   assign soft_reset = r_softReset;

endmodule

// File: rtl/router_sync_n.sv
// Router synchroniser: latches the destination of each packet, steers the
// FSM's write request to that channel's FIFO, reports that FIFO's full flag,
// and presents per-channel valid flags to the receivers.
// Optional stale-data flush timers are built when ROUTER_SYNC_TIMEOUT_EN is
// defined; otherwise soft_reset is tied low.
module router_sync_n
   import router_pkg::*;
#(
   parameter int NUM_CH  = ROUTER_NUM_CH,
   parameter int ADDR_W  = $clog2(NUM_CH),
   parameter int TIMEOUT = ROUTER_TIMEOUT
) (
   input logic            clk,
   input logic            reset,
   router_sync_n_if.slave bus
);

   logic [ADDR_W-1:0] r_sel;
   logic              r_addrErr;
   logic [NUM_CH-1:0] w_writeEnb;
   logic              w_fifoFull;

   // Reject impossible configurations at elaboration time.
   if (NUM_CH < 2 || NUM_CH > 8) begin : gBadNumCh
      $error("router_sync_n: NUM_CH must be in 2..8");
   end
   if (TIMEOUT < 2 || TIMEOUT > 255) begin : gBadTimeout
      $error("router_sync_n: TIMEOUT must be in 2..255");
   end

   // Destination latch: a new address replaces the old one only on detect_add;
   // an out-of-range address is remembered so its writes can be dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sel     <= '0;
         r_addrErr <= 1'b0;
      end else if (bus.detect_add) begin
         r_sel     <= bus.datain;
         r_addrErr <= ({1'b0, bus.datain} >= (ADDR_W + 1)'(NUM_CH));
      end
   end

   // Steer the write request and the full flag from the latched channel;
   // an invalid destination neither writes nor stalls the FSM.
   always_comb begin
      w_writeEnb = '0;
      w_fifoFull = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (r_sel == ADDR_W'(i) && !r_addrErr) begin
            w_writeEnb[i] = bus.write_enb_reg;
            w_fifoFull    = bus.full[i];
         end
      end
   end

   assign bus.write_enb = w_writeEnb;
   assign bus.fifo_full = w_fifoFull;
   assign bus.addr_err  = r_addrErr;
   assign bus.vld_out   = ~bus.empty;

`ifdef ROUTER_SYNC_TIMEOUT_EN
   logic [NUM_CH-1:0] w_cond;
   logic [NUM_CH-1:0] w_softReset;

   assign w_cond = ~bus.empty & ~bus.read_enb;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : gTimer
      router_timeout_timer #(
         .TIMEOUT (TIMEOUT)
      ) uTimer (
         .clk        (clk),
         .reset      (reset),
         .cond       (w_cond[gi]),
         .soft_reset (w_softReset[gi])
      );
   end

   assign bus.soft_reset = w_softReset;
`else
   assign bus.soft_reset = '0;
`endif

endmodule

// File: tb/tb_router_sync_n.sv
// Directed bench for router_sync_n (NUM_CH=3, TIMEOUT=30). Each stimulus
// window pushes its hand-computed expected outputs into a queue; a monitor
// pops one entry per falling edge and compares it against the DUT.
// Timer expectations depend on whether ROUTER_SYNC_TIMEOUT_EN is defined.
module tb_router_sync_n;

   typedef struct {
      logic [2:0] we;
      logic       ff;
      logic       err;
      logic [2:0] vld;
      logic [2:0] sr;
      string      tag;
   } exp_t;

`ifdef ROUTER_SYNC_TIMEOUT_EN
   localparam bit TimerOn = 1'b1;
`else
   localparam bit TimerOn = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   exp_t sbQ[$];

   router_sync_n_if #(.NUM_CH(3), .ADDR_W(2)) bus ();

   router_sync_n #(
      .NUM_CH  (3),
      .TIMEOUT (30)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   function automatic logic [2:0] srExp(input logic [2:0] v);
      return TimerOn ? v : 3'b000;
   endfunction

   task automatic checkOutput(input string name, input logic [2:0] act, input logic [2:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s actual=%b required=%b", name, act, req);
      end
   endtask

   // Drive one window of inputs just after a rising edge and queue the outputs
   // expected until the next rising edge.
   task automatic applyStimulus(input logic rst, input logic det, input logic wreg,
                                input logic [1:0] din, input logic [2:0] rd,
                                input logic [2:0] emp, input logic [2:0] fl,
                                input logic [2:0] we, input logic ff, input logic err,
                                input logic [2:0] sr, input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      reset             = rst;
      bus.detect_add    = det;
      bus.write_enb_reg = wreg;
      bus.datain        = din;
      bus.read_enb      = rd;
      bus.empty         = emp;
      bus.full          = fl;
      e.we  = we;
      e.ff  = ff;
      e.err = err;
      e.vld = ~emp;
      e.sr  = sr;
      e.tag = tag;
      sbQ.push_back(e);
   endtask

   task automatic idleGap(input int n);
      for (int k = 0; k < n; k++)
         applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 3'b111, 3'b000,
                       3'b000, 1'b0, 1'b0, 3'b000, $sformatf("gap%0d", k));
   endtask

   // Monitor: compare every queued expectation on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput({e.tag, ".write_enb"},  bus.write_enb,           e.we);
            checkOutput({e.tag, ".fifo_full"},  {2'b00, bus.fifo_full},  {2'b00, e.ff});
            checkOutput({e.tag, ".addr_err"},   {2'b00, bus.addr_err},   {2'b00, e.err});
            checkOutput({e.tag, ".vld_out"},    bus.vld_out,             e.vld);
            checkOutput({e.tag, ".soft_reset"}, bus.soft_reset,          e.sr);
         end
      end
   end

   // Directed stimulus.
   initial begin
      reset             = 1'b1;
      bus.detect_add    = 1'b0;
      bus.write_enb_reg = 1'b0;
      bus.datain        = 2'd0;
      bus.read_enb      = 3'b000;
      bus.empty         = 3'b111;
      bus.full          = 3'b000;

      // Reset state and address decode
      applyStimulus(1, 0, 0, 2'd0, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 3'b000, "rst");
      applyStimulus(0, 0, 0, 2'd0, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 3'b000, "idle");
      applyStimulus(0, 1, 0, 2'd2, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 3'b000, "ld2");
      applyStimulus(0, 0, 1, 2'd0, 3'b000, 3'b111, 3'b100, 3'b100, 1, 0, 3'b000, "we2full");
      applyStimulus(0, 0, 1, 2'd0, 3'b000, 3'b111, 3'b011, 3'b100, 0, 0, 3'b000, "we2nf");
      applyStimulus(0, 1, 1, 2'd1, 3'b000, 3'b111, 3'b100, 3'b100, 1, 0, 3'b000, "sameCyc");
      applyStimulus(0, 0, 1, 2'd0, 3'b000, 3'b111, 3'b010, 3'b010, 1, 0, 3'b000, "we1");
      applyStimulus(0, 1, 0, 2'd3, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 3'b000, "ld3");
      applyStimulus(0, 0, 1, 2'd0, 3'b000, 3'b111, 3'b111, 3'b000, 0, 1, 3'b000, "err");
      applyStimulus(0, 1, 1, 2'd0, 3'b000, 3'b111, 3'b111, 3'b000, 0, 1, 3'b000, "errHold");
      applyStimulus(0, 0, 1, 2'd0, 3'b000, 3'b111, 3'b001, 3'b001, 1, 0, 3'b000, "we0");
      applyStimulus(0, 1, 0, 2'd3, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 3'b000, "ld3b");
      applyStimulus(0, 0, 1, 2'd0, 3'b000, 3'b111, 3'b001, 3'b000, 0, 1, 3'b000, "err2");
      applyStimulus(1, 0, 1, 2'd0, 3'b000, 3'b111, 3'b001, 3'b001, 1, 0, 3'b000, "rstErr");
      applyStimulus(0, 1, 0, 2'd2, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 3'b000, "ld2b");
      applyStimulus(1, 0, 1, 2'd0, 3'b000, 3'b111, 3'b100, 3'b001, 0, 0, 3'b000, "rstSel");
      applyStimulus(0, 0, 0, 2'd0, 3'b000, 3'b011, 3'b000, 3'b000, 0, 0, 3'b000, "vld2");
      idleGap(2);

      // Channel 0 held unread: pulses after edges 30 and 61
      for (int j = 0; j < 66; j++)
         applyStimulus(0, 0, 0, 2'd0, 3'b000, 3'b110, 3'b000, 3'b000, 0, 0,
                       srExp((j == 30 || j == 61) ? 3'b001 : 3'b000), $sformatf("hold%0d", j));
      idleGap(2);

      // One read just before expiry restarts the count
      for (int j = 0; j < 62; j++)
         applyStimulus(0, 0, 0, 2'd0, (j == 29) ? 3'b001 : 3'b000, 3'b110, 3'b000, 3'b000, 0, 0,
                       srExp((j == 60) ? 3'b001 : 3'b000), $sformatf("read%0d", j));
      idleGap(2);

      // Channels 0 and 2 expire together, channel 1 stays quiet
      for (int j = 0; j < 33; j++)
         applyStimulus(0, 0, 0, 2'd0, 3'b000, 3'b010, 3'b000, 3'b000, 0, 0,
                       srExp((j == 30) ? 3'b101 : 3'b000), $sformatf("dual%0d", j));
      idleGap(2);

      // Reset at cnt=15 aborts the count; restart from release
      for (int j = 0; j < 50; j++)
         applyStimulus((j == 15) ? 1'b1 : 1'b0, 0, 0, 2'd0, 3'b000, 3'b110, 3'b000, 3'b000, 0, 0,
                       srExp((j == 46) ? 3'b001 : 3'b000), $sformatf("rstCnt%0d", j));
      idleGap(2);

      // Reset during the flush window kills the pulse immediately
      for (int j = 0; j < 33; j++)
         applyStimulus((j == 30) ? 1'b1 : 1'b0, 0, 0, 2'd0, 3'b000, 3'b110, 3'b000, 3'b000, 0, 0,
                       3'b000, $sformatf("rstFlush%0d", j));
      idleGap(2);

      for (int k = 0; k < 20 && sbQ.size() > 0; k++)
         @(negedge clk);
      #1;
      total++;
      if (sbQ.size() != 0) begin
         bad++;
         $display("[TB] FAIL drain actual=%0d required=0", sbQ.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/router_sync_n.md
ROUTER_SYNC_N -- requirements
Module: router_sync_n

Interface
REQ-001 Parameter NUM_CH, 3, number of output channels, legal range 2..8.
REQ-002 Parameter ADDR_W, $clog2(NUM_CH), destination address width.
REQ-003 Parameter TIMEOUT, 30, consecutive unread-valid cycles before channel soft reset, legal range 2..255.
REQ-004 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 Port reset  in  1  asynchronous, active-high reset.
REQ-006 Port detect_add  in  1  FSM strobe: datain carries a new packet's address.
REQ-007 Port write_enb_reg  in  1  FSM write request for the current packet.
REQ-008 Port datain  in  ADDR_W  destination address; sampled only when detect_add=1.
REQ-009 Port read_enb  in  NUM_CH  per-channel receiver read strobe.
REQ-010 Port empty  in  NUM_CH  per-channel FIFO empty flag.
REQ-011 Port full  in  NUM_CH  per-channel FIFO full flag.
REQ-012 Port write_enb  out  NUM_CH  one-hot FIFO write enable.
REQ-013 Port fifo_full  out  1  full flag of the selected channel, to FSM.
REQ-014 Port vld_out  out  NUM_CH  per-channel data valid, to receivers.
REQ-015 Port soft_reset  out  NUM_CH  per-channel one-cycle FIFO flush pulse.
REQ-016 Port addr_err  out  1  latched address is >= NUM_CH.

Function
REQ-017 Register sel (ADDR_W) SHALL load datain on any clock where detect_add=1; otherwise hold.
REQ-018 addr_err SHALL be registered: set with sel when loaded datain >= NUM_CH, cleared when loaded datain < NUM_CH; otherwise hold.
REQ-019 write_enb SHALL be combinational: bit sel high iff write_enb_reg=1 and addr_err=0; all zero otherwise.
REQ-020 fifo_full SHALL be combinational: full[sel] when addr_err=0, else 0 (writes to an invalid address are dropped, never stalled).
REQ-021 detect_add and write_enb_reg high in the same cycle: write_enb SHALL use the previously latched sel.
REQ-022 vld_out[i] SHALL equal ~empty[i], combinational, zero latency.
REQ-023 Per channel i, cond[i] = vld_out[i] & ~read_enb[i]; one timer FSM per channel with states IDLE, COUNT, FLUSH.
REQ-024 IDLE: cnt=0; cond -> COUNT with cnt=1; else stay.
REQ-025 COUNT: ~cond -> IDLE with cnt=0; cond and cnt==TIMEOUT-1 -> FLUSH with cnt=0; cond otherwise -> cnt+1.
REQ-026 FLUSH: lasts exactly one cycle, then -> IDLE regardless of cond; soft_reset[i]=1 only in FLUSH (registered, state-decoded).
REQ-027 cnt width SHALL be $clog2(TIMEOUT+1); cnt SHALL never exceed TIMEOUT-1 and SHALL never wrap.
REQ-028 Channels SHALL be fully independent; simultaneous timeouts on several channels SHALL pulse all of them in the same cycle.

Reset
REQ-029 On reset=1, immediately and asynchronously: sel=0, addr_err=0, all timers IDLE, cnt=0, soft_reset=0; write_enb and fifo_full follow from these.
REQ-030 Reset asserted mid-count or during FLUSH SHALL abort the pulse; counting restarts from IDLE after release.

Configuration
REQ-031 Macro ROUTER_SYNC_TIMEOUT_EN defined: timer FSMs and counters built per REQ-023..028.
REQ-032 Macro undefined: no timer logic instantiated; soft_reset SHALL be constant 0; all other behaviour unchanged.

Structure
REQ-033 Package router_pkg SHALL hold the timer state enum (IDLE, COUNT, FLUSH) and default constants ROUTER_NUM_CH=3, ROUTER_TIMEOUT=30.
REQ-034 Per-channel timer SHALL be sub-module router_timeout_timer, instantiated NUM_CH times via generate; parameters TIMEOUT; ports clk, reset, cond, soft_reset.

Verification
REQ-035 NUM_CH=3: detect_add=1, datain=2, then write_enb_reg=1 -> write_enb=3'b100, fifo_full tracks full[2].
REQ-036 NUM_CH=3: latch datain=3 -> addr_err=1 next cycle, write_enb=0 with write_enb_reg=1, fifo_full=0; latch datain=1 -> addr_err=0.
REQ-037 TIMEOUT=30: empty[0]=0, read_enb[0]=0 from edge 1 -> soft_reset[0] high after edge 30 only, low after edge 31; re-pulses after edge 61 if held.
REQ-038 TIMEOUT=30: cond held 29 cycles then read_enb[0]=1 one cycle -> no pulse; cnt restarts from 1 on next cond.
REQ-039 cond on channels 0 and 2 from same edge -> soft_reset=3'b101 in one cycle; channel 1 stays 0.
REQ-040 reset asserted at cnt=15 -> soft_reset=0 and cnt=0 immediately, no pulse; with macro undefined, soft_reset=0 in all above cases.
